vc_wrr_scheduler: RTL and testbench

//  Weighted round-robin scheduler draining the four class FIFOs (fifo0..fifo3) into the

---
 rtl/vc_wrr_scheduler_pkg.sv | 22 ++
 rtl/vc_wrr_scheduler_rr_rotate_sel.sv | 25 ++
 rtl/vc_wrr_scheduler.sv | 97 +++++++++
 tb/tb_vc_wrr_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_wrr_scheduler_pkg.sv
// rtl/vc_wrr_scheduler_pkg.sv - shared constants, state encoding and helpers for the VC WRR scheduler
package vc_wrr_scheduler_pkg;

    localparam int NUM_VC           = 4;
    localparam int DEFAULT_WEIGHT_W = 3;

    // Class field position inside the 12-bit word, for downstream consumers
    localparam int WORD_W    = 12;
    localparam int CLASS_LSB = 8;
    localparam int CLASS_MSB = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONFIG = 2'd1,
        ST_ACTIVE = 2'd2
    } sched_state_e;

    function automatic logic [NUM_VC-1:0] vc_onehot(input logic [1:0] idx);
        return NUM_VC'(1) << idx;
    endfunction

endpackage

// File: rtl/vc_wrr_scheduler_rr_rotate_sel.sv
// rtl/vc_wrr_scheduler_rr_rotate_sel.sv - rotating-priority pick over 4 requests, starting at ptr+1
module rr_rotate_sel (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    output logic       o_found,
    output logic [1:0] o_idx
);

    logic [1:0] w_cand;

    // Walk from lowest to highest priority so the nearest hit after ptr wins; ptr itself is last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = i_ptr;
        w_cand  = i_ptr;
        for (int k = 4; k >= 1; k--) begin
            w_cand = i_ptr + 2'(k);
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/vc_wrr_scheduler.sv
// rtl/vc_wrr_scheduler.sv - weighted round-robin pop scheduler for four class FIFOs into one output FIFO
module vc_wrr_scheduler
    import vc_wrr_scheduler_pkg::*;
#(
    parameter int WEIGHT_W = DEFAULT_WEIGHT_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_init,
    input  logic [NUM_VC*WEIGHT_W-1:0] i_cfg_weights,
    input  logic [NUM_VC-1:0]          i_empty,
    input  logic                       i_down_afull,
    output logic [NUM_VC-1:0]          o_pop,
    output logic                       o_valid,
    output logic [1:0]                 o_grant_idx,
    output logic                       o_idle
);

    sched_state_e                     r_state;
    logic [NUM_VC-1:0][WEIGHT_W-1:0]  r_weight;
    logic [NUM_VC-1:0][WEIGHT_W-1:0]  r_credit;
    logic [1:0]                       r_ptr;
    logic [1:0]                       r_grant_idx;
    logic                             r_valid;

    logic [NUM_VC-1:0] w_elig;
    logic              w_ptr_ok;
    logic              w_scan_found;
    logic [1:0]        w_scan_idx;
    logic [1:0]        w_sel;
    logic              w_fire;

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            w_elig[i] = !i_empty[i] && (r_weight[i] != '0);
        end
    end

    assign w_ptr_ok = w_elig[r_ptr] && (r_credit[r_ptr] != '0);

    // Hand-over target is computed every cycle so a switch costs no bubble.
    rr_rotate_sel u_rr_rotate_sel (
        .i_req   (w_elig),
        .i_ptr   (r_ptr),
        .o_found (w_scan_found),
        .o_idx   (w_scan_idx)
    );

    assign w_sel  = w_ptr_ok ? r_ptr : w_scan_idx;
    assign w_fire = (r_state == ST_ACTIVE) && !reset && !i_down_afull && (w_ptr_ok || w_scan_found);
    assign o_pop  = w_fire ? vc_onehot(w_sel) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_weight    <= '0;
            r_credit    <= '0;
            r_ptr       <= '0;
            r_grant_idx <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_valid <= w_fire;
            case (r_state)
                ST_IDLE: begin
                    if (i_init) r_state <= ST_CONFIG;
                end
                ST_CONFIG: begin
                    r_weight    <= i_cfg_weights;
                    r_credit    <= '0;
                    r_credit[0] <= i_cfg_weights[WEIGHT_W-1:0];
                    r_ptr       <= '0;
                    r_state     <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (w_fire) begin
                        r_grant_idx <= w_sel;
                        if (w_ptr_ok) begin
                            r_credit[r_ptr] <= r_credit[r_ptr] - WEIGHT_W'(1);
                        end else begin
                            // Selected class is eligible, so its weight is non-zero here.
                            r_credit[w_sel] <= r_weight[w_sel] - WEIGHT_W'(1);
                            r_ptr           <= w_sel;
                        end
                    end
                    if (i_init) r_state <= ST_CONFIG;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_valid     = r_valid;
    assign o_grant_idx = r_grant_idx;
    assign o_idle      = (r_state == ST_IDLE);

endmodule

// File: tb/tb_vc_wrr_scheduler.sv
// tb/tb_vc_wrr_scheduler.sv - self-checking bench for vc_wrr_scheduler against a queue-count reference model
module tb_vc_wrr_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_init;
    logic [11:0] i_cfg_weights;
    logic [3:0]  i_empty;
    logic        i_down_afull;
    logic [3:0]  o_pop;
    logic        o_valid;
    logic [1:0]  o_grant_idx;
    logic        o_idle;

    always #5 clk = ~clk;

    vc_wrr_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .i_init        (i_init),
        .i_cfg_weights (i_cfg_weights),
        .i_empty       (i_empty),
        .i_down_afull  (i_down_afull),
        .o_pop         (o_pop),
        .o_valid       (o_valid),
        .o_grant_idx   (o_grant_idx),
        .o_idle        (o_idle)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: 0=idle 1=config 2=active; FIFOs modelled as word counts.
    int m_state;
    int m_w[4];
    int m_cred[4];
    int m_ptr;
    int m_grant;
    bit m_valid;
    int cnt[4];
    int pop_log[$];

    function automatic logic [11:0] pack_w(input int w0, input int w1, input int w2, input int w3);
        return {3'(w3), 3'(w2), 3'(w1), 3'(w0)};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_ptr   = 0;
        m_grant = 0;
        m_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_w[i]    = 0;
            m_cred[i] = 0;
        end
    endtask

    function automatic bit elig(input int c);
        return (cnt[c] > 0) && (m_w[c] > 0);
    endfunction

    function automatic int model_pick(input bit afull);
        if (m_state != 2 || afull) return -1;
        if (elig(m_ptr) && m_cred[m_ptr] > 0) return m_ptr;
        for (int k = 1; k <= 4; k++) begin
            if (elig((m_ptr + k) % 4)) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic cycle(input bit rst, input bit init, input bit afull, input logic [11:0] cfg);
        int         exp_idx;
        logic [3:0] exp_pop;
        logic [3:0] emp;
        for (int i = 0; i < 4; i++) emp[i] = (cnt[i] == 0);
        reset         = rst;
        i_init        = init;
        i_down_afull  = afull;
        i_cfg_weights = cfg;
        i_empty       = emp;
        @(negedge clk);
        exp_idx = rst ? -1 : model_pick(afull);
        exp_pop = (exp_idx < 0) ? 4'b0000 : 4'(1 << exp_idx);
        checks++;
        if (o_pop !== exp_pop) begin
            failures++;
            $display("FAIL pop t=%0t got=%b exp=%b", $time, o_pop, exp_pop);
        end
        checks++;
        if (o_valid !== m_valid) begin
            failures++;
            $display("FAIL valid t=%0t got=%b exp=%b", $time, o_valid, m_valid);
        end
        checks++;
        if (o_grant_idx !== 2'(m_grant)) begin
            failures++;
            $display("FAIL grant_idx t=%0t got=%0d exp=%0d", $time, o_grant_idx, m_grant);
        end
        checks++;
        if (o_idle !== (m_state == 0)) begin
            failures++;
            $display("FAIL idle t=%0t got=%b exp=%b", $time, o_idle, (m_state == 0));
        end
        checks++;
        if ((o_pop & emp) !== 4'b0000) begin
            failures++;
            $display("FAIL underflow t=%0t pop=%b empty=%b exp_overlap=0000", $time, o_pop, emp);
        end
        for (int i = 0; i < 4; i++) if (o_pop[i] === 1'b1) pop_log.push_back(i);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_valid = (exp_idx >= 0);
            if (exp_idx >= 0) begin
                cnt[exp_idx]--;
                m_grant = exp_idx;
                if (exp_idx == m_ptr && m_cred[m_ptr] > 0) begin
                    m_cred[m_ptr]--;
                end else begin
                    m_ptr           = exp_idx;
                    m_cred[exp_idx] = m_w[exp_idx] - 1;
                end
            end
            case (m_state)
                0: if (init) m_state = 1;
                1: begin
                    for (int i = 0; i < 4; i++) begin
                        m_w[i]    = int'(cfg[i*3 +: 3]);
                        m_cred[i] = 0;
                    end
                    m_cred[0] = m_w[0];
                    m_ptr     = 0;
                    m_state   = 2;
                end
                default: if (init) m_state = 1;
            endcase
        end
        #1;
    endtask

    task automatic set_cnt(input int c0, input int c1, input int c2, input int c3);
        cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
    endtask

    task automatic test_reset();
        set_cnt(2, 2, 2, 2);
        cycle(1, 0, 0, 12'h0);
        cycle(1, 0, 0, 12'h0);
        for (int n = 0; n < 3; n++) cycle(0, 0, 0, 12'h0);
    endtask

    task automatic test_wrr_order();
        int exp_seq[10] = '{0, 0, 1, 2, 3, 0, 0, 1, 2, 3};
        logic [11:0] cfg = pack_w(2, 1, 1, 1);
        cycle(1, 0, 0, cfg);
        set_cnt(4, 4, 4, 4);
        pop_log.delete();
        cycle(0, 1, 0, cfg);
        for (int n = 0; n < 20; n++) cycle(0, 0, 0, cfg);
        checks++;
        if (pop_log.size() < 10) begin
            failures++;
            $display("FAIL wrr_order_len got=%0d exp>=10", pop_log.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (pop_log[i] != exp_seq[i]) begin
                    failures++;
                    $display("FAIL wrr_order[%0d] got=%0d exp=%0d", i, pop_log[i], exp_seq[i]);
                end
            end
        end
    endtask

    task automatic test_single_class();
        logic [11:0] cfg = pack_w(3, 2, 1, 4);
        cycle(1, 0, 0, cfg);
        set_cnt(0, 0, 3, 0);
        pop_log.delete();
        cycle(0, 1, 0, cfg);
        for (int n = 0; n < 8; n++) cycle(0, 0, 0, cfg);
        checks++;
        if (pop_log.size() != 3 || pop_log[0] != 2 || pop_log[1] != 2 || pop_log[2] != 2) begin
            failures++;
            $display("FAIL single_class pops=%0d exp=3 of class 2", pop_log.size());
        end
    endtask

    task automatic test_backpressure();
        int exp_seq[4] = '{0, 0, 0, 1};
        logic [11:0] cfg = pack_w(3, 1, 1, 1);
        cycle(1, 0, 0, cfg);
        set_cnt(4, 4, 4, 4);
        pop_log.delete();
        cycle(0, 1, 0, cfg);
        cycle(0, 0, 0, cfg);
        cycle(0, 0, 0, cfg);
        for (int n = 0; n < 3; n++) cycle(0, 0, 1, cfg);
        for (int n = 0; n < 6; n++) cycle(0, 0, 0, cfg);
        checks++;
        if (pop_log.size() < 4) begin
            failures++;
            $display("FAIL backpressure_len got=%0d exp>=4", pop_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (pop_log[i] != exp_seq[i]) begin
                    failures++;
                    $display("FAIL backpressure[%0d] got=%0d exp=%0d", i, pop_log[i], exp_seq[i]);
                end
            end
        end
    endtask

    task automatic test_disabled_class();
        logic [11:0] cfg_off = pack_w(1, 0, 1, 1);
        logic [11:0] cfg_on  = pack_w(1, 2, 1, 1);
        cycle(1, 0, 0, cfg_off);
        set_cnt(0, 8, 0, 0);
        pop_log.delete();
        cycle(0, 1, 0, cfg_off);
        for (int n = 0; n < 6; n++) cycle(0, 0, 0, cfg_off);
        checks++;
        if (pop_log.size() != 0) begin
            failures++;
            $display("FAIL disabled_no_pop got=%0d exp=0", pop_log.size());
        end
        cycle(0, 1, 0, cfg_on);
        for (int n = 0; n < 10; n++) cycle(0, 0, 0, cfg_on);
        checks++;
        if (pop_log.size() != 8) begin
            failures++;
            $display("FAIL disabled_drain got=%0d exp=8", pop_log.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [11:0] cfg = pack_w(1, 1, 1, 3);
        cycle(1, 0, 0, cfg);
        set_cnt(0, 0, 0, 6);
        pop_log.delete();
        cycle(0, 1, 0, cfg);
        cycle(0, 0, 0, cfg);
        cycle(0, 0, 0, cfg);
        cycle(0, 0, 0, cfg);
        cycle(1, 0, 0, cfg);
        for (int n = 0; n < 4; n++) cycle(0, 0, 0, cfg);
        checks++;
        if (pop_log.size() != 2) begin
            failures++;
            $display("FAIL reset_mid_pops got=%0d exp=2", pop_log.size());
        end
    endtask

    task automatic test_init_restart();
        int exp_seq[5] = '{0, 1, 0, 0, 1};
        logic [11:0] cfg_a = pack_w(1, 2, 1, 1);
        logic [11:0] cfg_b = pack_w(2, 1, 1, 1);
        cycle(1, 0, 0, cfg_a);
        set_cnt(4, 4, 4, 4);
        pop_log.delete();
        cycle(0, 1, 0, cfg_a);
        cycle(0, 0, 0, cfg_a);
        cycle(0, 0, 0, cfg_a);
        cycle(0, 1, 0, cfg_b);
        for (int n = 0; n < 4; n++) cycle(0, 0, 0, cfg_b);
        checks++;
        if (pop_log.size() < 5) begin
            failures++;
            $display("FAIL init_restart_len got=%0d exp>=5", pop_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (pop_log[i] != exp_seq[i]) begin
                    failures++;
                    $display("FAIL init_restart[%0d] got=%0d exp=%0d", i, pop_log[i], exp_seq[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] cfg = 12'($urandom);
        cycle(1, 0, 0, cfg);
        for (int i = 0; i < 4; i++) cnt[i] = $urandom_range(0, 5);
        cycle(0, 1, 0, cfg);
        for (int n = 0; n < 300; n++) begin
            bit init_now = ($urandom_range(0, 49) == 0);
            bit rst_now  = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 3) == 0) cnt[$urandom_range(0, 3)]++;
            if (init_now) cfg = 12'($urandom);
            cycle(rst_now, init_now || (m_state == 0 && $urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), cfg);
        end
    endtask

    initial begin
        reset         = 1'b1;
        i_init        = 1'b0;
        i_cfg_weights = '0;
        i_empty       = 4'hF;
        i_down_afull  = 1'b0;
        set_cnt(0, 0, 0, 0);
        model_reset();
        test_reset();
        test_wrr_order();
        test_single_class();
        test_backpressure();
        test_disabled_class();
        test_reset_mid_burst();
        test_init_restart();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
